// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: occupancy state encoding and width.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_SKID_FULL = 2'd2
  } pipe_state_t;

  localparam int OCC_W = 2;

  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_t s);
    case (s)
      ST_FULL:      occ_of = 2'd1;
      ST_SKID_FULL: occ_of = 2'd2;
      default:      occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, cleared only by reset; used for back-pressure statistics.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer, flush and
// stall counter. Control bits of any empty slot are held at zero so bubbles never write state.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  pipe_state_t       state, state_nxt;
  logic              accept, emit;
  logic              load_in, load_skid_in, load_from_skid, clear_main;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  assign out_valid = (state != ST_EMPTY);
  assign emit      = out_valid && out_ready;
  assign accept    = in_valid && in_ready;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occupancy = occ_of(state);

  always_comb begin
    state_nxt      = state;
    load_in        = 1'b0;
    load_skid_in   = 1'b0;
    load_from_skid = 1'b0;
    clear_main     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_FULL;
          load_in   = 1'b1;
        end
      end
      ST_FULL: begin
        if (accept && emit) begin
          load_in = 1'b1;
        end else if (accept && (SKID != 0)) begin
          state_nxt    = ST_SKID_FULL;
          load_skid_in = 1'b1;
        end else if (emit) begin
          state_nxt  = ST_EMPTY;
          clear_main = 1'b1;
        end
      end
      ST_SKID_FULL: begin
        if (emit) begin
          state_nxt      = ST_FULL;
          load_from_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush overrides everything except reset; an emit in this cycle still happened downstream.
    if (flush) begin
      state_nxt      = ST_EMPTY;
      load_in        = 1'b0;
      load_skid_in   = 1'b0;
      load_from_skid = 1'b0;
      clear_main     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Main (head) entry: data holds through bubbles, ctrl is zeroed whenever the slot empties.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      main_data <= '0;
      main_ctrl <= '0;
    end else if (load_in) begin
      main_data <= in_data;
      main_ctrl <= in_ctrl;
    end else if (load_from_skid) begin
      main_data <= skid_data;
      main_ctrl <= skid_ctrl;
    end else if (clear_main) begin
      main_ctrl <= '0;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] skid_data_q;
      logic [CTRL_W-1:0] skid_ctrl_q;
      logic              ready_q;

      // Ready is registered from the next state so no ready path runs from out_ready to in_ready.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          skid_ctrl_q <= '0;
          ready_q     <= 1'b1;
        end else begin
          ready_q <= (state_nxt != ST_SKID_FULL);
          if (flush || load_from_skid) begin
            skid_ctrl_q <= '0;
          end else if (load_skid_in) begin
            skid_ctrl_q <= in_ctrl;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (load_skid_in) begin
          skid_data_q <= in_data;
        end
      end

      assign skid_data = skid_data_q;
      assign skid_ctrl = skid_ctrl_q;
      assign in_ready  = ready_q;
    end else begin : g_noskid
      assign skid_data = '0;
      assign skid_ctrl = '0;
      assign in_ready  = !out_valid || out_ready;
    end
  endgenerate

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall (
    .clk   (clk),
    .resetn(resetn),
    .inc   (out_valid && !out_ready),
    .count (stall_cycles)
  );

endmodule
